// File: rtl/dmem_responder.sv
// dmem_responder: word-organised SRAM slave for the core's dmem bus with wait states and range faults.
// Optional macro DMEM_ERROR_INJECT_EN adds an err_inject input that forces an access fault on a request.
module dmem_responder #(
  parameter int unsigned DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
`ifdef DMEM_ERROR_INJECT_EN
  input  logic        err_inject,
`endif
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_error
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [32:0] SPAN     = 33'(DEPTH) << 2;
  localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;

  logic          accept;
  logic [31:0]   accOffset;
  logic          accInRange;
  logic          accFault;
  logic [AW-1:0] accIdx;
  logic [3:0]    accStrb;

  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [3:0]    strb_q;
  logic          fault_q;

  logic          doResp;
  logic [AW-1:0] opIdx;
  logic [31:0]   opWdata;
  logic [3:0]    opStrb;
  logic          opFault;

  logic          ready_q;
  logic          error_q;
  logic [31:0]   rdata_q;

  logic [31:0]   mem [DEPTH];

  // Range test on the unsigned offset so a window ending at 2^32 still works and nothing aliases.
  assign accOffset  = mem_addr - BASE_ADDR;
  assign accInRange = ({1'b0, accOffset} < SPAN);
  assign accIdx     = accOffset[AW+1:2];
  assign accStrb    = mem_instr ? 4'b0000 : mem_wstrb;
`ifdef DMEM_ERROR_INJECT_EN
  assign accFault   = !accInRange || err_inject;
`else
  assign accFault   = !accInRange;
`endif

  assign accept = mem_valid && ((state_q == IDLE) || (state_q == RESP));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q   <= '0;
      wdata_q <= '0;
      strb_q  <= 4'b0000;
      fault_q <= 1'b0;
    end else if (accept) begin
      idx_q   <= accIdx;
      wdata_q <= mem_wdata;
      strb_q  <= accStrb;
      fault_q <= accFault;
    end
  end

  // With zero wait states the edge that accepts is also the edge that enters RESP, so use live inputs.
  assign doResp  = ((state_q == BUSY) && (cnt_q == 4'd0)) || ((LATENCY == 0) && accept);
  assign opIdx   = (LATENCY == 0) ? accIdx    : idx_q;
  assign opWdata = (LATENCY == 0) ? mem_wdata : wdata_q;
  assign opStrb  = (LATENCY == 0) ? accStrb   : strb_q;
  assign opFault = (LATENCY == 0) ? accFault  : fault_q;

  always_ff @(posedge clk) begin
    if (doResp && !opFault) begin
      for (int i = 0; i < 4; i++) begin
        if (opStrb[i]) begin
          mem[opIdx][8*i +: 8] <= opWdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= doResp;
      error_q <= doResp && opFault;
      rdata_q <= (doResp && !opFault && (opStrb == 4'b0000)) ? mem[opIdx] : 32'h0;
    end
  end

  assign mem_ready = ready_q;
  assign mem_error = error_q;
  assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench driving three responders (LATENCY 1, 0 and 3) with directed vectors.
// Define DMEM_ERROR_INJECT_EN to also drive err_inject on every instance.
`timescale 1ns/1ps
module tb_dmem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    int          tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        validS [3];
  logic        instrS [3];
  logic [31:0] addrS  [3];
  logic [31:0] wdataS [3];
  logic [3:0]  wstrbS [3];
`ifdef DMEM_ERROR_INJECT_EN
  logic        injS   [3];
`endif
  logic        readyS [3];
  logic [31:0] rdataS [3];
  logic        errorS [3];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;
  int tagCnt   = 0;
  bit monOn    = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : gDut
    dmem_responder #(
      .DEPTH    (4096),
      .BASE_ADDR(32'h0000_0000),
      .LATENCY  ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) uDut (
      .clk       (clk),
      .rst       (rst),
      .mem_valid (validS[g]),
      .mem_instr (instrS[g]),
      .mem_addr  (addrS[g]),
      .mem_wdata (wdataS[g]),
      .mem_wstrb (wstrbS[g]),
`ifdef DMEM_ERROR_INJECT_EN
      .err_inject(injS[g]),
`endif
      .mem_ready (readyS[g]),
      .mem_rdata (rdataS[g]),
      .mem_error (errorS[g])
    );
  end

  function automatic int latOf(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
  endfunction

  function automatic int qSize(input int g);
    case (g)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void qPush(input int g, input exp_t e);
    case (g)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic exp_t qPop(input int g);
    exp_t e;
    case (g)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    return e;
  endfunction

  // Called just after a rising edge; holds the request for exactly one sampling edge.
  task automatic applyStimulus(input int g, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] ws, input logic inj, input logic instr,
                               input logic [31:0] expRd, input logic expErr, input bit track);
    exp_t e;
    validS[g] = 1'b1;
    addrS[g]  = a;
    wdataS[g] = wd;
    wstrbS[g] = ws;
    instrS[g] = instr;
`ifdef DMEM_ERROR_INJECT_EN
    injS[g]   = inj;
`else
    if (inj) $display("[TB] note: err_inject not present in this build");
`endif
    if (track) begin
      e.rdata = expRd;
      e.err   = expErr;
      e.cyc   = cyc + 1 + latOf(g);
      e.tag   = tagCnt;
      tagCnt++;
      qPush(g, e);
    end
    @(posedge clk);
    #1;
    validS[g] = 1'b0;
    instrS[g] = 1'b0;
    wstrbS[g] = 4'b0000;
`ifdef DMEM_ERROR_INJECT_EN
    injS[g]   = 1'b0;
`endif
  endtask

  task automatic waitDrain(input int g);
    exp_t junk;
    int n = 0;
    while (qSize(g) != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (qSize(g) != 0) begin
      failures++;
      $display("[TB] FAIL drain_timeout inst%0d: pending=%0d, need 0", g, qSize(g));
      while (qSize(g) != 0) junk = qPop(g);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input int g);
    exp_t e;
    checks++;
    if (readyS[g] === 1'b1) begin
      if (qSize(g) == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_ready inst%0d cyc=%0d: got ready=1 rdata=%h err=%b, need ready=0",
                 g, cyc, rdataS[g], errorS[g]);
      end else begin
        e = qPop(g);
        if (rdataS[g] !== e.rdata || errorS[g] !== e.err || cyc != e.cyc) begin
          failures++;
          $display("[TB] FAIL resp inst%0d tag%0d: got rdata=%h err=%b cyc=%0d, need rdata=%h err=%b cyc=%0d",
                   g, e.tag, rdataS[g], errorS[g], cyc, e.rdata, e.err, e.cyc);
        end
      end
    end else if (readyS[g] !== 1'b0 || rdataS[g] !== 32'h0 || errorS[g] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_outputs inst%0d cyc=%0d: got ready=%b rdata=%h err=%b, need 0/0/0",
               g, cyc, readyS[g], rdataS[g], errorS[g]);
    end
  endtask

  always @(negedge clk) begin
    if (monOn) begin
      for (int g = 0; g < 3; g++) checkOutput(g);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int g = 0; g < 3; g++) begin
      validS[g] = 1'b0;
      instrS[g] = 1'b0;
      addrS[g]  = 32'h0;
      wdataS[g] = 32'h0;
      wstrbS[g] = 4'b0000;
`ifdef DMEM_ERROR_INJECT_EN
      injS[g]   = 1'b0;
`endif
    end
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (readyS[g] !== 1'b0 || errorS[g] !== 1'b0 || rdataS[g] !== 32'h0) begin
        failures++;
        $display("[TB] FAIL reset_state inst%0d: got ready=%b err=%b rdata=%h, need 0/0/0",
                 g, readyS[g], errorS[g], rdataS[g]);
      end
    end
    monOn = 1'b1;

    // LATENCY=1: basic write/read, fetch, byte strobes, range boundaries.
    applyStimulus(0, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1); waitDrain(0);
    applyStimulus(0, 32'h10, 32'h0, 4'b0000, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1); waitDrain(0);
    applyStimulus(0, 32'h10, 32'h0, 4'b0000, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1); waitDrain(0);
    applyStimulus(0, 32'h20, 32'h11223344, 4'b1111, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1); waitDrain(0);
    applyStimulus(0, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1); waitDrain(0);
    applyStimulus(0, 32'h20, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h11BB33DD, 1'b0, 1'b1); waitDrain(0);
    applyStimulus(0, 32'h0, 32'hA5A5A5A5, 4'b1111, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1); waitDrain(0);
    applyStimulus(0, 32'h4000, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1); waitDrain(0);
    applyStimulus(0, 32'h4000, 32'hFFFFFFFF, 4'b1111, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1); waitDrain(0);
    applyStimulus(0, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b1); waitDrain(0);
    applyStimulus(0, 32'h3FFC, 32'h0BADF00D, 4'b1111, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1); waitDrain(0);
    applyStimulus(0, 32'h3FFF, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0BADF00D, 1'b0, 1'b1); waitDrain(0);
    applyStimulus(0, 32'h8000_0010, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1); waitDrain(0);
    applyStimulus(0, 32'hFFFF_FFFC, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1); waitDrain(0);

    // LATENCY=0: back-to-back write then read accepted in the write's RESP cycle.
    applyStimulus(1, 32'h8, 32'h0, 4'b1111, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1); waitDrain(1);
    applyStimulus(1, 32'h8, 32'h00000055, 4'b0001, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1, 32'h8, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h00000055, 1'b0, 1'b1);
    applyStimulus(1, 32'h8, 32'hFFFF0000, 4'b1100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1, 32'h8, 32'h0, 4'b0000, 1'b0, 1'b0, 32'hFFFF0055, 1'b0, 1'b1);
    waitDrain(1);

    // LATENCY=3: reset one cycle into BUSY drops the write.
    applyStimulus(2, 32'h30, 32'hCAFEF00D, 4'b1111, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1); waitDrain(2);
    applyStimulus(2, 32'h30, 32'h0, 4'b0000, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0, 1'b1); waitDrain(2);
    applyStimulus(2, 32'h30, 32'h12345678, 4'b1111, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (readyS[2] !== 1'b0 || errorS[2] !== 1'b0 || rdataS[2] !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_mid_busy: got ready=%b err=%b rdata=%h, need 0/0/0",
               readyS[2], errorS[2], rdataS[2]);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(2, 32'h30, 32'h0, 4'b0000, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0, 1'b1); waitDrain(2);

`ifdef DMEM_ERROR_INJECT_EN
    applyStimulus(0, 32'h10, 32'h0, 4'b0000, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1); waitDrain(0);
    applyStimulus(0, 32'h10, 32'hFFFFFFFF, 4'b1111, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1); waitDrain(0);
    applyStimulus(0, 32'h10, 32'h0, 4'b0000, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1); waitDrain(0);
    applyStimulus(2, 32'h30, 32'h0, 4'b0000, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1); waitDrain(2);
    applyStimulus(1, 32'h8, 32'h0, 4'b1111, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1); waitDrain(1);
    applyStimulus(1, 32'h8, 32'h0, 4'b0000, 1'b0, 1'b0, 32'hFFFF0055, 1'b0, 1'b1); waitDrain(1);
`endif

    repeat (5) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory slave that answers the core's data-memory request interface.
- Accepts one request at a time and returns a single-cycle response pulse: mem_ready with mem_rdata, or mem_ready with mem_error.
- Sits on the far side of the dmem bus: the execute stage issues requests and stalls until mem_ready arrives, then takes either load data or an access fault.
- Provides on-chip word-organised SRAM with byte-strobed writes, programmable wait states and out-of-range error responses.

Parameters:
DEPTH, 4096, number of 32-bit words of storage (power of two)
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH*4 aligned
LATENCY, 1, wait cycles inserted before the response (0..15)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
mem_valid  input  1  request strobe
mem_instr  input  1  request is an instruction fetch; treated like a read, no other effect
mem_addr  input  32  byte address; bits [1:0] ignored
mem_wdata  input  32  store data
mem_wstrb  input  4  byte write enables; 4'b0000 = read, nonzero = write
mem_ready  output  1  response valid, exactly one cycle per accepted request
mem_rdata  output  32  read data, valid while mem_ready=1
mem_error  output  1  access fault, valid while mem_ready=1

Behaviour:
- Reset is asynchronous, active-low, and clk/rst naming follows the codebase convention.
- Reset values: state=IDLE, cnt=0, mem_ready=0, mem_error=0, mem_rdata=0. Storage is not reset.
- Reset asserted mid-request drops the request. No write is committed and no response is produced.
- All outputs are registered.
- FSM states: IDLE, BUSY, RESP.
- Accept: mem_valid=1 while in IDLE or RESP.
  - Latch addr, wdata, wstrb, and in_range = (addr >= BASE_ADDR) & (addr < BASE_ADDR + 4*DEPTH).
  - If LATENCY=0, go to RESP. Otherwise go to BUSY with cnt=LATENCY-1.
- mem_valid in BUSY is ignored. The requester holds or re-issues it; the core holds it while stalled.
- BUSY: if cnt=0, go to RESP on the next edge; else cnt decrements.
- Response timing: request sampled on edge N, mem_ready=1 during cycle N+1+LATENCY.
- Data and write commit happen on the edge entering RESP:
  - In-range read: mem_rdata = mem[(addr-BASE_ADDR)>>2], mem_error=0.
  - In-range write: bytes with wstrb[i]=1 get wdata[8i+7:8i]; mem_rdata=0, mem_error=0.
  - Out-of-range access: no write, mem_rdata=0, mem_error=1.
- RESP lasts exactly one cycle. Then go to IDLE, or accept a new request if mem_valid=1, giving back-to-back service.
  - Back-to-back minimum period is LATENCY+1 cycles per request.
- mem_ready, mem_error and mem_rdata return to 0 in every cycle that is not RESP.
- Ordering: a request accepted during the RESP cycle of a write observes that write (read-after-write coherent).
- Address wrap: index = (addr-BASE_ADDR)[log2(DEPTH)+1:2]. Out-of-range addresses never alias.

Optional Feature:
- Macro: DMEM_ERROR_INJECT_EN.
- Defined:
  - Adds input err_inject (1 bit), sampled at accept.
  - If err_inject=1, the request completes with mem_error=1 and mem_rdata=0, at normal latency, with no write.
  - Used to exercise the core's load/store access-fault path.
- Undefined: port absent; errors arise only from out-of-range addresses.

Test Plan:
- LATENCY=1: write 0xDEADBEEF to 0x10 with wstrb 1111, then read 0x10 -> each mem_ready exactly 1 cycle, 2 cycles after valid; read rdata=0xDEADBEEF, error=0.
- Byte strobes: word 0x20 holds 0x11223344; write wdata 0xAABBCCDD with wstrb 0101 -> read returns 0x11BB33DD.
- Out of range, DEPTH=4096, BASE=0: read 0x4000 -> mem_ready=1, mem_error=1, rdata=0. Write 0x4000 leaves word 0 unchanged.
- LATENCY=0, back-to-back: write 0x55 to 0x8 (strobe 0001), then read 0x8 accepted in the RESP cycle -> ready in consecutive cycles; read returns low byte 0x55.
- Reset mid-request, LATENCY=3: write 0x12345678 to 0x30, assert rst=0 one cycle into BUSY -> outputs 0 immediately; a read of 0x30 after reset returns the old value.
- DMEM_ERROR_INJECT_EN: read 0x10 with err_inject=1 -> mem_error=1 with LATENCY timing. Write with err_inject=1 -> memory unchanged.
